// File: rtl/sreg_tx_ctrl_pkg.sv
// Shared definitions for the serializer controller: FSM encoding and
// the helper that sizes the bit counter from the word width.
package sreg_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width: clog2(N), never below one bit.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sreg_tx_ctrl_if.sv
// Word source / serial sink bundle for the serializer controller.
// master = word source and serial consumer side, slave = controller.
interface sreg_tx_ctrl_if #(
    parameter int N     = 8,
    parameter int DIV_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [N-1:0]     s_data;
    logic [DIV_W-1:0] div;
    logic             sout;
    logic             frame;
    logic             bit_strobe;
    logic             done;
    logic             busy;

    modport master (
        output s_valid, s_data, div,
        input  s_ready, sout, frame, bit_strobe, done, busy
    );

    modport slave (
        input  s_valid, s_data, div,
        output s_ready, sout, frame, bit_strobe, done, busy
    );
endinterface

// File: rtl/sreg_tx_ctrl_shift_reg_sync.sv
// Parallel-load shift register with synchronous clear. Load wins over
// shift; shifting fills the vacated position with zero.
module shift_reg_sync #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Register update: clear, load, shift toward the output end, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {N{1'b0}};
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            if (MSB_FIRST != 0) begin
                q <= {q[N-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[N-1:1]};
            end
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/sreg_tx_ctrl.sv
// Serializer controller: takes one word per handshake and sends it out
// one bit per programmable bit period, with frame/strobe/done markers.
// All outputs are decoded from registered state; s_ready additionally
// drops while reset is held so no word is taken during reset.
module sreg_tx_ctrl
    import sreg_tx_ctrl_pkg::*;
#(
    parameter int N         = 8,
    parameter int DIV_W     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic          clk,
    input  logic          reset,
    sreg_tx_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_w(N);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_l_r;
    logic [N-1:0]       q_s;
    logic               accept_s;
    logic               strobe_s;
    logic               last_bit_s;
    logic               shift_en_s;
    logic               ser_bit_s;

    // Bit that sits at the output end of the shift register.
    function automatic logic pick_bit(input logic [N-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[N-1];
        end else begin
            return v[0];
        end
    endfunction

    assign accept_s   = (state_r == IDLE) && bus.s_valid;
    assign strobe_s   = (state_r == SHIFT) && (div_cnt_r == {DIV_W{1'b0}});
    assign last_bit_s = (bit_cnt_r == CNT_W'(N - 1));
    assign shift_en_s = strobe_s && !last_bit_s;
    assign ser_bit_s  = pick_bit(q_s);

    shift_reg_sync #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .shift_en (shift_en_s),
        .d        (bus.s_data),
        .q        (q_s)
    );

    // Next-state decode for IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.s_valid) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (strobe_s && last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; reset always wins over a coincident accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bit-period divider and bit counter; div is captured only at accept
    // so later changes on the input cannot disturb a frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
            div_l_r   <= {DIV_W{1'b0}};
        end else if (accept_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            div_cnt_r <= bus.div;
            div_l_r   <= bus.div;
        end else if (state_r == SHIFT) begin
            if (strobe_s) begin
                if (!last_bit_s) begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    div_cnt_r <= div_l_r;
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                    div_cnt_r <= {DIV_W{1'b0}};
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
                div_cnt_r <= div_cnt_r - DIV_W'(1);
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            div_cnt_r <= div_cnt_r;
        end
    end

    // Output decode from the registered state; sout is zero outside a frame.
    always_comb begin
        bus.s_ready    = 1'b0;
        bus.frame      = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = 1'b0;
        bus.sout       = 1'b0;
        case (state_r)
            IDLE: begin
                bus.s_ready = !reset;
            end
            SHIFT: begin
                bus.frame      = 1'b1;
                bus.bit_strobe = strobe_s;
                bus.busy       = 1'b1;
                bus.sout       = ser_bit_s;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            default: begin
                bus.s_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sreg_tx_ctrl.sv
// Scoreboard bench: the driver pushes the hand-computed bit sequence of
// each accepted word; a negedge monitor pops it when a frame starts and
// checks every frame cycle, the done pulse and the following ready cycle.
module tb_sreg_tx_ctrl;

    typedef struct {
        logic [7:0] seq;        // seq[i] = i-th bit expected on sout
        int         div;
        int         abort_len;  // nonzero: frame cut by reset after this many cycles
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    int   fcyc[2];
    bit   active[2];
    bit   need_ready[2];
    bit   rst_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    sreg_tx_ctrl_if #(.N(8), .DIV_W(8)) bus0 ();
    sreg_tx_ctrl_if #(.N(8), .DIV_W(8)) bus1 ();

    sreg_tx_ctrl #(.N(8), .DIV_W(8), .MSB_FIRST(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    sreg_tx_ctrl #(.N(8), .DIV_W(8), .MSB_FIRST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int ch, input logic frame, input logic sout,
                       input logic bs, input logic dn, input logic rdy,
                       input logic bsy);
        string p;
        int    idx;
        exp_t  e;
        p = (ch == 0) ? "lsb" : "msb";
        if (reset) chk({p, "_ready_in_reset"}, int'(rdy), 0);
        if (rst_prev) begin
            chk({p, "_frame_after_reset"}, int'(frame), 0);
            chk({p, "_busy_after_reset"}, int'(bsy), 0);
        end
        if (frame) begin
            if (!active[ch]) begin
                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                    chk({p, "_unexpected_frame"}, 1, 0);
                    e.seq = 8'h00; e.div = 0; e.abort_len = 0;
                end else if (ch == 0) begin
                    e = q0.pop_front();
                end else begin
                    e = q1.pop_front();
                end
                cur[ch] = e;
                active[ch] = 1'b1;
                fcyc[ch] = 0;
            end
            fcyc[ch]++;
            idx = (fcyc[ch] - 1) / (cur[ch].div + 1);
            if (idx > 7) begin
                chk({p, "_frame_overrun"}, fcyc[ch], 8 * (cur[ch].div + 1));
            end else begin
                chk($sformatf("%s_sout_c%0d", p, fcyc[ch]), int'(sout), int'(cur[ch].seq[idx]));
                chk($sformatf("%s_strobe_c%0d", p, fcyc[ch]), int'(bs),
                    ((fcyc[ch] % (cur[ch].div + 1)) == 0) ? 1 : 0);
            end
            chk({p, "_done_in_frame"}, int'(dn), 0);
            chk({p, "_busy_in_frame"}, int'(bsy), 1);
            need_ready[ch] = 1'b0;
        end else begin
            if (active[ch]) begin
                active[ch] = 1'b0;
                if (cur[ch].abort_len != 0) begin
                    chk({p, "_abort_len"}, fcyc[ch], cur[ch].abort_len);
                    chk({p, "_no_done_on_abort"}, int'(dn), 0);
                end else begin
                    chk({p, "_frame_len"}, fcyc[ch], 8 * (cur[ch].div + 1));
                    chk({p, "_done_pulse"}, int'(dn), 1);
                    chk({p, "_busy_in_done"}, int'(bsy), 1);
                    chk({p, "_ready_in_done"}, int'(rdy), 0);
                    need_ready[ch] = 1'b1;
                end
            end else begin
                if (need_ready[ch] && !reset) begin
                    chk({p, "_ready_after_done"}, int'(rdy), 1);
                    chk({p, "_idle_after_done"}, int'(bsy), 0);
                end
                need_ready[ch] = 1'b0;
                chk({p, "_spurious_done"}, int'(dn), 0);
            end
            chk({p, "_sout_idle"}, int'(sout), 0);
            chk({p, "_strobe_idle"}, int'(bs), 0);
        end
    endtask

    // Monitor: sample both controllers mid-cycle, away from the active edge.
    always @(negedge clk) begin
        mon(0, bus0.frame, bus0.sout, bus0.bit_strobe, bus0.done, bus0.s_ready, bus0.busy);
        mon(1, bus1.frame, bus1.sout, bus1.bit_strobe, bus1.done, bus1.s_ready, bus1.busy);
        rst_prev = reset;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic [7:0] dv);
        if (ch == 0) begin
            bus0.s_valid = v; bus0.s_data = d; bus0.div = dv;
        end else begin
            bus1.s_valid = v; bus1.s_data = d; bus1.div = dv;
        end
    endtask

    // Present a word until accepted; returns in frame cycle 1.
    task automatic send(input int ch, input logic [7:0] d, input logic [7:0] dv,
                        input logic [7:0] seq, input bit hold, input int abort_len,
                        output int acc_cyc);
        bit   ok;
        logic rdy;
        exp_t e;
        ok = 1'b0;
        acc_cyc = 0;
        drive(ch, 1'b1, d, dv);
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            rdy = (ch == 0) ? bus0.s_ready : bus1.s_ready;
            if (rdy) begin
                ok = 1'b1;
                acc_cyc = cyc_cnt;
                e.seq = seq; e.div = int'(dv); e.abort_len = abort_len;
                if (ch == 0) q0.push_back(e); else q1.push_back(e);
            end
            cyc();
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (!hold) drive(ch, 1'b0, d, dv);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            cyc();
            idle = (q0.size() == 0) && (q1.size() == 0) && !active[0] && !active[1]
                   && !bus0.busy && !bus1.busy;
        end
        if (!idle) chk("idle_timeout", 0, 1);
        cyc();
    endtask

    initial begin
        int a1, a2;
        drive(0, 1'b1, 8'h5A, 8'd0);
        drive(1, 1'b1, 8'h5A, 8'd0);
        reset = 1'b1;
        // Reset held three cycles with s_valid high.
        repeat (3) cyc();
        reset = 1'b0;
        drive(0, 1'b0, 8'h00, 8'd0);
        drive(1, 1'b0, 8'h00, 8'd0);
        #1;
        chk("ready_after_release0", int'(bus0.s_ready), 1);
        chk("ready_after_release1", int'(bus1.s_ready), 1);
        cyc();

        // A5, one bit per clock, LSB first.
        send(0, 8'hA5, 8'd0, 8'hA5, 1'b0, 0, a1);
        wait_idle();

        // 81 with four clocks per bit.
        send(0, 8'h81, 8'd3, 8'h81, 1'b0, 0, a1);
        wait_idle();

        // div/data change mid-frame; second word waits for IDLE.
        send(0, 8'h3C, 8'd3, 8'h3C, 1'b0, 0, a1);
        repeat (4) cyc();
        send(0, 8'hFF, 8'd0, 8'hFF, 1'b0, 0, a2);
        chk("accept_gap_div3", a2 - a1, 34);
        wait_idle();

        // Reset during frame cycle 3 aborts without done.
        send(0, 8'hFF, 8'd0, 8'hFF, 1'b0, 3, a1);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_idle();
        send(0, 8'hFF, 8'd0, 8'hFF, 1'b0, 0, a1);
        wait_idle();

        // MSB first, back to back: 0F then F0.
        send(1, 8'h0F, 8'd0, 8'hF0, 1'b1, 0, a1);
        send(1, 8'hF0, 8'd0, 8'h0F, 1'b1, 0, a2);
        drive(1, 1'b0, 8'h00, 8'd0);
        chk("accept_gap_msb", a2 - a1, 10);
        wait_idle();

        // Maximum period.
        send(0, 8'h01, 8'hFF, 8'h01, 1'b0, 0, a1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
